// File: rtl/scale_tile_fifo.sv
// scale_tile_fifo: splits FP32 scale beats into mantissa/exponent fields and queues up to DEPTH full tiles.
// Optional macro SCALE_FTZ_EN flushes zero/denormal scales (exp==0) to mant=0, exp=0.
module scale_tile_fifo #(
  parameter int MAT_SIZE  = 16,
  parameter int LANES_NUM = 16,
  parameter int FP_DATA_W = 32,
  parameter int FP_MANT_W = 23,
  parameter int FP_EXP_W  = 8,
  parameter int DEPTH     = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   s_valid_i,
  output logic                                   s_ready_o,
  input  logic [LANES_NUM*FP_DATA_W-1:0]         s_data_i,
  output logic                                   m_valid_o,
  input  logic                                   m_ready_i,
  output logic [FP_MANT_W*MAT_SIZE*MAT_SIZE-1:0] mantissa_scale_o,
  output logic [FP_EXP_W*MAT_SIZE*MAT_SIZE-1:0]  exp_scale_o,
  output logic [$clog2(DEPTH+1)-1:0]             count_o
);
  localparam int ELEMS  = MAT_SIZE * MAT_SIZE;
  localparam int BEATS  = ELEMS / LANES_NUM;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int FLD_W  = FP_MANT_W + FP_EXP_W;

  if (ELEMS % LANES_NUM != 0) begin : g_bad_lanes
    $fatal(1, "scale_tile_fifo: MAT_SIZE*MAT_SIZE must be a multiple of LANES_NUM");
  end
  if (DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "scale_tile_fifo: DEPTH must be a power of two >= 1");
  end

  function automatic logic [FLD_W-1:0] split_scale(input logic [FLD_W-1:0] w);
    logic [FP_MANT_W-1:0] mant;
    logic [FP_EXP_W-1:0]  expo;
    mant = w[FP_MANT_W-1:0];
    expo = w[FLD_W-1:FP_MANT_W];
`ifdef SCALE_FTZ_EN
    if (expo == '0) mant = '0;
`endif
    return {expo, mant};
  endfunction

  logic [FP_MANT_W*ELEMS-1:0] mant_mem_q [DEPTH];
  logic [FP_EXP_W*ELEMS-1:0]  exp_mem_q  [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [BEAT_W-1:0] in_beat_q, in_beat_d;

  logic [FP_MANT_W-1:0] lane_mant [LANES_NUM];
  logic [FP_EXP_W-1:0]  lane_exp  [LANES_NUM];
  logic [LANES_NUM-1:0] sign_unused;

  logic s_fire, last_beat, commit, pop;

  // Lane split: sign bit is dropped since scales are always positive
  for (genvar l = 0; l < LANES_NUM; l++) begin : g_lane
    logic [FP_DATA_W-1:0] word;
    assign word = s_data_i[l*FP_DATA_W +: FP_DATA_W];
    assign {lane_exp[l], lane_mant[l]} = split_scale(word[FLD_W-1:0]);
    assign sign_unused[l] = ^word[FP_DATA_W-1:FLD_W];
  end

  assign s_ready_o = !rst && (count_q < CNT_W'(DEPTH));
  assign s_fire    = s_valid_i && s_ready_o;
  assign last_beat = (in_beat_q == BEAT_W'(BEATS - 1));
  assign commit    = s_fire && last_beat;
  assign m_valid_o = (count_q != '0);
  assign pop       = m_valid_o && m_ready_i;
  assign count_o   = count_q;

  assign mantissa_scale_o = m_valid_o ? mant_mem_q[rd_ptr_q] : '0;
  assign exp_scale_o      = m_valid_o ? exp_mem_q[rd_ptr_q]  : '0;

  always_comb begin
    in_beat_d = in_beat_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (s_fire) begin
      in_beat_d = last_beat ? '0 : in_beat_q + 1'b1;
    end
    if (commit) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({commit, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_beat_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      in_beat_q <= in_beat_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Slot storage: written only on accepted beats, never reset
  always_ff @(posedge clk) begin
    if (s_fire) begin
      for (int l = 0; l < LANES_NUM; l++) begin
        mant_mem_q[wr_ptr_q][(int'(in_beat_q)*LANES_NUM + l)*FP_MANT_W +: FP_MANT_W] <= lane_mant[l];
        exp_mem_q[wr_ptr_q][(int'(in_beat_q)*LANES_NUM + l)*FP_EXP_W +: FP_EXP_W]    <= lane_exp[l];
      end
    end
  end

endmodule

// File: tb/tb_scale_tile_fifo.sv
// Scoreboard bench for scale_tile_fifo: accepted beats build expected tiles in a queue, a negedge monitor compares.
module tb_scale_tile_fifo;
  localparam int MAT_SIZE  = 16;
  localparam int LANES_NUM = 16;
  localparam int FP_DATA_W = 32;
  localparam int FP_MANT_W = 23;
  localparam int FP_EXP_W  = 8;
  localparam int DEPTH     = 2;
  localparam int ELEMS     = MAT_SIZE * MAT_SIZE;
  localparam int BEATS     = ELEMS / LANES_NUM;
  localparam int CNT_W     = $clog2(DEPTH + 1);

  typedef logic [FP_MANT_W*ELEMS-1:0] mant_t;
  typedef logic [FP_EXP_W*ELEMS-1:0]  exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid_i = 1'b0;
  logic m_ready_i = 1'b0;
  logic [LANES_NUM*FP_DATA_W-1:0] s_data_i = '0;
  logic s_ready_o, m_valid_o;
  mant_t mantissa_scale_o;
  exp_t  exp_scale_o;
  logic [CNT_W-1:0] count_o;

  scale_tile_fifo #(
    .MAT_SIZE(MAT_SIZE), .LANES_NUM(LANES_NUM), .FP_DATA_W(FP_DATA_W),
    .FP_MANT_W(FP_MANT_W), .FP_EXP_W(FP_EXP_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .mantissa_scale_o(mantissa_scale_o), .exp_scale_o(exp_scale_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  mant_t exp_mant_q[$];
  exp_t  exp_exp_q[$];
  mant_t part_mant;
  exp_t  part_exp;
  int    part_beat = 0;

  logic [FP_DATA_W-1:0] tile_w [ELEMS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_tile(input string name, input mant_t m, input exp_t e);
    int idx;
    n_checks++;
    if (mantissa_scale_o !== m || exp_scale_o !== e) begin
      idx = 0;
      for (int i = ELEMS - 1; i >= 0; i--)
        if (mantissa_scale_o[i*FP_MANT_W +: FP_MANT_W] !== m[i*FP_MANT_W +: FP_MANT_W] ||
            exp_scale_o[i*FP_EXP_W +: FP_EXP_W] !== e[i*FP_EXP_W +: FP_EXP_W]) idx = i;
      n_fail++;
      $display("FAIL %s elem %0d: got mant=0x%0h exp=0x%0h, expected mant=0x%0h exp=0x%0h at %0t",
               name, idx, mantissa_scale_o[idx*FP_MANT_W +: FP_MANT_W], exp_scale_o[idx*FP_EXP_W +: FP_EXP_W],
               m[idx*FP_MANT_W +: FP_MANT_W], e[idx*FP_EXP_W +: FP_EXP_W], $time);
    end
  endtask

  // Reference field extraction from the IEEE-754 layout using plain arithmetic
  function automatic void ref_split(input logic [FP_DATA_W-1:0] w,
                                    output logic [FP_MANT_W-1:0] m, output logic [FP_EXP_W-1:0] e);
    longint unsigned mt, ex;
    mt = longint'(w) % (64'd1 << FP_MANT_W);
    ex = (longint'(w) / (64'd1 << FP_MANT_W)) % (64'd1 << FP_EXP_W);
`ifdef SCALE_FTZ_EN
    if (ex == 0) mt = 0;
`endif
    m = FP_MANT_W'(mt);
    e = FP_EXP_W'(ex);
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [FP_MANT_W-1:0] m;
    logic [FP_EXP_W-1:0]  e;
    int idx;
    if (rst) begin
      check("s_ready_in_rst", 64'(s_ready_o), 64'd0);
      exp_mant_q.delete();
      exp_exp_q.delete();
      part_beat = 0;
    end else begin
      check("count_o", 64'(count_o), 64'(exp_mant_q.size()));
      check("m_valid_o", 64'(m_valid_o), 64'(exp_mant_q.size() != 0));
      check("s_ready_o", 64'(s_ready_o), 64'(exp_mant_q.size() < DEPTH));
      if (exp_mant_q.size() != 0) check_tile("head_tile", exp_mant_q[0], exp_exp_q[0]);
      else                        check_tile("empty_zero", '0, '0);
      if (exp_mant_q.size() != 0 && m_ready_i) begin
        void'(exp_mant_q.pop_front());
        void'(exp_exp_q.pop_front());
      end
      if (s_valid_i && s_ready_o) begin
        for (int l = 0; l < LANES_NUM; l++) begin
          idx = part_beat * LANES_NUM + l;
          ref_split(s_data_i[l*FP_DATA_W +: FP_DATA_W], m, e);
          part_mant[idx*FP_MANT_W +: FP_MANT_W] = m;
          part_exp[idx*FP_EXP_W +: FP_EXP_W]    = e;
        end
        part_beat++;
        if (part_beat == BEATS) begin
          exp_mant_q.push_back(part_mant);
          exp_exp_q.push_back(part_exp);
          part_beat = 0;
        end
      end
    end
  end

  task automatic make_tile(input int mode);
    for (int e = 0; e < ELEMS; e++) begin
      case (mode)
        0:       tile_w[e] = 32'h3F80_0000;
        1:       tile_w[e] = 32'h4000_0000 + 32'(e);
        3:       tile_w[e] = (e % 4 == 0) ? 32'h0000_0001 :
                             (e % 4 == 1) ? {9'd0, 23'($urandom)} : $urandom;
        default: tile_w[e] = $urandom;
      endcase
    end
  endtask

  task automatic send_beat(input int b, input bit pop_with);
    bit fired;
    int waited;
    fired = 1'b0;
    waited = 0;
    for (int l = 0; l < LANES_NUM; l++) s_data_i[l*FP_DATA_W +: FP_DATA_W] = tile_w[b*LANES_NUM + l];
    s_valid_i = 1'b1;
    if (pop_with) m_ready_i = 1'b1;
    while (!fired) begin
      @(negedge clk);
      fired = s_ready_o;
      @(posedge clk);
      #1;
      if (!fired) begin
        waited++;
        if (waited > 300) begin
          n_checks++;
          n_fail++;
          $display("FAIL beat_accept_timeout: beat %0d not accepted, s_ready_o=%0b", b, s_ready_o);
          fired = 1'b1;
        end
      end
    end
    s_valid_i = 1'b0;
    if (pop_with) m_ready_i = 1'b0;
    for (int l = 0; l < LANES_NUM; l++) s_data_i[l*FP_DATA_W +: FP_DATA_W] = $urandom;
  endtask

  task automatic send_tile(input int mode, input bit gaps, input bit pop_last, input int nbeats);
    make_tile(mode);
    for (int b = 0; b < nbeats; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_beat(b, pop_last && (b == BEATS - 1));
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    m_ready_i = 1'b1;
    while (m_valid_o && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    m_ready_i = 1'b0;
    check("drain_empty", 64'(m_valid_o), 64'd0);
  endtask

  bit rand_done;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_m_valid", 64'(m_valid_o), 64'd0);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_data_zero", 64'(|mantissa_scale_o | |exp_scale_o), 64'd0);

    // One tile of 1.0 scales, held: visible right after the last-beat edge
    send_tile(0, 1'b0, 1'b0, BEATS);
    check("lat_m_valid", 64'(m_valid_o), 64'd1);
    check("lat_count", 64'(count_o), 64'd1);
    check("one_exp_e0", 64'(exp_scale_o[FP_EXP_W-1:0]), 64'd127);
    check("one_mant_e255", 64'(mantissa_scale_o[ELEMS*FP_MANT_W-1 -: FP_MANT_W]), 64'd0);

    // Ramp tile with gaps, fills the FIFO
    send_tile(1, 1'b1, 1'b0, BEATS);
    check("full_s_ready", 64'(s_ready_o), 64'd0);
    check("full_count", 64'(count_o), 64'(DEPTH));
    drain();

    // Three tiles back-to-back with the consumer stalled
    send_tile(2, 1'b0, 1'b0, BEATS);
    send_tile(2, 1'b0, 1'b0, BEATS);
    fork
      send_tile(2, 1'b0, 1'b0, BEATS);
      begin
        repeat (6) begin @(posedge clk); #1; end
        check("stall_s_ready", 64'(s_ready_o), 64'd0);
        m_ready_i = 1'b1;
        @(posedge clk);
        #1 m_ready_i = 1'b0;
        check("pop_s_ready", 64'(s_ready_o), 64'd1);
      end
    join
    check("third_count", 64'(count_o), 64'd2);
    drain();

    // Commit and pop on the same edge
    send_tile(2, 1'b0, 1'b0, BEATS);
    send_tile(1, 1'b0, 1'b1, BEATS);
    check("commit_pop_count", 64'(count_o), 64'd1);
    check("commit_pop_head_exp", 64'(exp_scale_o[FP_EXP_W-1:0]), 64'd128);
    check("commit_pop_head_mant", 64'(mantissa_scale_o[5*FP_MANT_W +: FP_MANT_W]), 64'd5);
    drain();

    // Reset in the middle of a partial tile, with one tile stored
    send_tile(0, 1'b0, 1'b0, BEATS);
    send_tile(2, 1'b0, 1'b0, 7);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_m_valid", 64'(m_valid_o), 64'd0);
    check("midrst_count", 64'(count_o), 64'd0);
    send_tile(1, 1'b1, 1'b0, BEATS);
    check("postrst_count", 64'(count_o), 64'd1);
    drain();

    // Denormal and zero-exponent lanes
    send_tile(3, 1'b0, 1'b0, BEATS);
`ifdef SCALE_FTZ_EN
    check("denorm_mant", 64'(mantissa_scale_o[FP_MANT_W-1:0]), 64'd0);
`else
    check("denorm_mant", 64'(mantissa_scale_o[FP_MANT_W-1:0]), 64'd1);
`endif
    check("denorm_exp", 64'(exp_scale_o[FP_EXP_W-1:0]), 64'd0);
    drain();

    // Random traffic on both sides
    rand_done = 1'b0;
    fork
      begin
        repeat (8) send_tile(2, 1'b1, 1'b0, BEATS);
        rand_done = 1'b1;
      end
      begin
        int cyc;
        cyc = 0;
        while (!rand_done && cyc < 5000) begin
          m_ready_i = ($urandom_range(0, 2) == 0);
          @(posedge clk);
          #1;
          cyc++;
        end
        m_ready_i = 1'b0;
      end
    join
    drain();

    repeat (3) @(posedge clk);
    #1;
    check("final_model_empty", 64'(exp_mant_q.size()), 64'd0);
    check("final_partial", 64'(part_beat), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
